// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DATA_WIDTH_DEF = 8;

    // Counter must hold values 0..w, so it needs clog2(w+1) bits.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mult_addsub.sv
// Combinational W-bit add/subtract used for the accumulator update.
module mult_addsub #(
    parameter int unsigned W = 9
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic [W-1:0] sum_c_o
);

    assign sum_c_o = sub_i ? (a_i - b_i) : (a_i + b_i);

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add multiplier, signed/unsigned, one W-cycle multiply
// in flight, valid/ready on both the operand and the result side.
module seq_shift_add_mult
    import mult_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_in_valid,
    output logic                      o_in_ready,
    input  logic                      i_signed,
    input  logic [DATA_WIDTH-1:0]     i_multiplicand,
    input  logic [DATA_WIDTH-1:0]     i_multiplier,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic [2*DATA_WIDTH-1:0]   o_product,
    output logic                      o_busy
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned AW    = W + 1;
    localparam int unsigned PW    = 2 * W;
    localparam int unsigned CNT_W = cnt_width(DATA_WIDTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     m_q, m_d;
    logic [W-1:0]     q_q, q_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic             mode_q, mode_d;
    logic [PW-1:0]    product_q, product_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic             last_c;
    logic [AW-1:0]    addend_c;
    logic [AW-1:0]    sum_c;
    logic [AW-1:0]    acc_add_c;
    logic [AW-1:0]    acc_sh_c;
    logic [W-1:0]     q_sh_c;

    // One iteration: conditional add (subtract for the signed sign bit), then shift {ACC,Q} right.
    assign last_c    = (cnt_q == CNT_W'(W - 1));
    assign addend_c  = mode_q ? {m_q[W-1], m_q} : {1'b0, m_q};
    assign acc_add_c = q_q[0] ? sum_c : acc_q;
    assign acc_sh_c  = {mode_q & acc_add_c[AW-1], acc_add_c[AW-1:1]};
    assign q_sh_c    = {acc_add_c[0], q_q[W-1:1]};

    mult_addsub #(
        .W (AW)
    ) u_addsub (
        .a_i     (acc_q),
        .b_i     (addend_c),
        .sub_i   (mode_q & last_c),
        .sum_c_o (sum_c)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        m_d       = m_q;
        q_d       = q_q;
        acc_d     = acc_q;
        mode_d    = mode_q;
        product_d = product_q;

        unique case (state_q)
            IDLE: begin
                if (i_in_valid) begin
                    m_d     = i_multiplicand;
                    q_d     = i_multiplier;
                    acc_d   = '0;
                    mode_d  = i_signed;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_sh_c;
                q_d   = q_sh_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_c) begin
                    product_d = {acc_sh_c[W-1:0], q_sh_c};
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (i_out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == CALC) || (state_d == DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            m_q         <= '0;
            q_q         <= '0;
            acc_q       <= '0;
            mode_q      <= 1'b0;
            product_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            m_q         <= m_d;
            q_q         <= q_d;
            acc_q       <= acc_d;
            mode_q      <= mode_d;
            product_q   <= product_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign o_in_ready  = in_ready_q;
    assign o_out_valid = out_valid_q;
    assign o_product   = product_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Self-checking bench for seq_shift_add_mult at W=8 and W=16 against an arithmetic reference.
module tb_seq_shift_add_mult;

    logic        clk;
    logic        rst;
    logic        sel16;
    logic        in_valid;
    logic        sgn;
    logic        out_ready;
    logic [15:0] a;
    logic [15:0] b;

    logic        r8, v8, bz8;
    logic [15:0] p8;
    logic        r16, v16, bz16;
    logic [31:0] p16;

    logic        in_ready, out_valid, busy;
    logic [31:0] product;

    int n_chk;
    int n_pass;

    seq_shift_add_mult #(.DATA_WIDTH(8)) dut8 (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_in_valid     (in_valid & ~sel16),
        .o_in_ready     (r8),
        .i_signed       (sgn),
        .i_multiplicand (a[7:0]),
        .i_multiplier   (b[7:0]),
        .o_out_valid    (v8),
        .i_out_ready    (out_ready & ~sel16),
        .o_product      (p8),
        .o_busy         (bz8)
    );

    seq_shift_add_mult #(.DATA_WIDTH(16)) dut16 (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_in_valid     (in_valid & sel16),
        .o_in_ready     (r16),
        .i_signed       (sgn),
        .i_multiplicand (a),
        .i_multiplier   (b),
        .o_out_valid    (v16),
        .i_out_ready    (out_ready & sel16),
        .o_product      (p16),
        .o_busy         (bz16)
    );

    assign in_ready  = sel16 ? r16  : r8;
    assign out_valid = sel16 ? v16  : v8;
    assign busy      = sel16 ? bz16 : bz8;
    assign product   = sel16 ? p16  : {16'h0000, p8};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Exact product of the w-bit operands interpreted per mode, masked to 2*w bits.
    function automatic logic [31:0] ref_mul(input int w, input bit s,
                                            input logic [15:0] x, input logic [15:0] y);
        longint ax, by, p;
        ax = longint'(x);
        by = longint'(y);
        if (s && x[w-1]) ax = ax - (longint'(1) << w);
        if (s && y[w-1]) by = by - (longint'(1) << w);
        p = ax * by;
        return 32'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic issue(input bit s, input logic [15:0] x, input logic [15:0] y, input bit linger);
        bit rdy;
        int tries;
        rdy   = 1'b0;
        tries = 0;
        while (!rdy && tries < 200) begin
            in_valid = 1'b1;
            sgn      = s;
            a        = x;
            b        = y;
            rdy      = in_ready;
            tick();
            tries++;
        end
        chk("accept", 64'(rdy), 64'd1);
        if (linger) begin
            in_valid = 1'b1;
            a        = 16'($urandom);
            b        = 16'($urandom);
            sgn      = 1'($urandom);
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic finish(input int w, input logic [31:0] exp, input int hold, input bit keep_valid);
        int lat;
        lat = 0;
        while (!out_valid && lat < 4 * w + 8) begin
            tick();
            lat++;
        end
        chk("latency", 64'(lat), 64'(w));
        chk("product", 64'(product), 64'(exp));
        chk("in_ready_done", 64'(in_ready), 64'd0);
        chk("busy_done", 64'(busy), 64'd1);
        if (keep_valid) begin
            in_valid = 1'b1;
            a        = 16'd3;
            b        = 16'd3;
            sgn      = 1'b0;
        end
        repeat (hold) tick();
        if (hold > 0) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_product", 64'(product), 64'(exp));
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        if (!keep_valid) in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("release_valid", 64'(out_valid), 64'd0);
        chk("release_ready", 64'(in_ready), 64'd1);
        chk("retain_product", 64'(product), 64'(exp));
    endtask

    task automatic run_random(input int w, input int n);
        logic [15:0] mask, x, y;
        bit s;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        for (int k = 0; k < n; k++) begin
            x = 16'($urandom) & mask;
            y = 16'($urandom) & mask;
            s = 1'($urandom);
            issue(s, x, y, 1'($urandom));
            finish(w, ref_mul(w, s, x, y), int'($urandom_range(0, 3)), 1'b0);
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        int seen;
        n_chk     = 0;
        n_pass    = 0;
        sel16     = 1'b0;
        in_valid  = 1'b0;
        sgn       = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        rst       = 1'b1;
        tick();
        do_reset();

        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_product", 64'(product), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        // Directed W=8 corner cases.
        issue(1'b0, 16'h00FF, 16'h00FF, 1'b0);
        finish(8, 32'h0000FE01, 0, 1'b0);
        issue(1'b1, 16'h0080, 16'h0080, 1'b0);
        finish(8, 32'h00004000, 0, 1'b0);
        issue(1'b1, 16'h0080, 16'h007F, 1'b0);
        finish(8, 32'h0000C080, 0, 1'b0);
        issue(1'b1, 16'h00FF, 16'h00FF, 1'b0);
        finish(8, 32'h00000001, 0, 1'b0);
        issue(1'b1, 16'h0005, 16'h00FD, 1'b0);
        finish(8, 32'h0000FFF1, 0, 1'b0);
        issue(1'b0, 16'h0000, 16'h00A5, 1'b0);
        finish(8, 32'h00000000, 0, 1'b0);

        // Mode switch back-to-back.
        issue(1'b0, 16'h00FF, 16'h0002, 1'b0);
        finish(8, 32'h000001FE, 0, 1'b0);
        issue(1'b1, 16'h00FF, 16'h0002, 1'b0);
        finish(8, 32'h0000FFFE, 0, 1'b0);

        // Back-pressure with a pending operand held valid throughout.
        issue(1'b0, 16'h000B, 16'h000D, 1'b0);
        finish(8, 32'h0000008F, 20, 1'b1);
        tick();
        chk("bp_accept_busy", 64'(busy), 64'd1);
        chk("bp_accept_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        finish(8, 32'h00000009, 0, 1'b0);

        // Reset in the middle of CALC aborts the multiply.
        issue(1'b0, 16'h00C8, 16'h0064, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_product", 64'(product), 64'd0);
        chk("abort_ready", 64'(in_ready), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        seen = 0;
        repeat (12) begin
            tick();
            if (out_valid) seen++;
        end
        chk("abort_no_valid", 64'(seen), 64'd0);
        issue(1'b0, 16'h0006, 16'h0007, 1'b0);
        finish(8, 32'h0000002A, 0, 1'b0);

        run_random(8, 1500);

        // W=16 instance.
        sel16 = 1'b1;
        do_reset();
        chk("rst16_product", 64'(product), 64'd0);
        chk("rst16_ready", 64'(in_ready), 64'd1);
        issue(1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
        finish(16, 32'hFFFE0001, 0, 1'b0);
        issue(1'b1, 16'h8000, 16'h8000, 1'b0);
        finish(16, 32'h40000000, 0, 1'b0);
        issue(1'b1, 16'h8000, 16'h7FFF, 1'b0);
        finish(16, 32'hC0008000, 0, 1'b0);

        run_random(16, 1000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
